// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM encoding and
// the width helper for the bit counter.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width needed to hold a count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_loader_serializer.sv
// Word buffer for the chain loader. Holds one bitstream word, presents it
// LSB first on a registered head/shift_en pair, and asks for the next word
// early enough that consecutive words shift with no idle cycle.
//
// Handshake: a word transfers on a prog_clk edge where cfg_valid and
// cfg_ready are both 1. cfg_ready never depends on cfg_valid; the source may
// hold cfg_valid high indefinitely and must keep cfg_data stable until the
// transfer edge.
module ccff_loader_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,       // pass active; low flushes the buffer
  input  logic [CNT_W-1:0]  avail,     // chain bits not yet shifted
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              head,
  output logic              shift_en
);

  localparam int BL_W = $clog2(WORD_W + 1);

  // sreg[0] is the bit on head while shift_en is high; bits_left counts
  // that bit plus everything still waiting behind it.
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] sreg_nxt;
  logic [BL_W-1:0]   bits_left;
  logic [BL_W-1:0]   bl_nxt;
  logic [BL_W-1:0]   stay;
  logic [CNT_W-1:0]  room;
  logic [BL_W-1:0]   n_use;
  logic              accept;

  // Readiness: buffer drains this cycle and the chain still wants bits.
  always_comb begin
    stay      = bits_left - BL_W'(shift_en);
    room      = avail - CNT_W'(shift_en);
    cfg_ready = run && (stay == '0) && (room != '0);
    accept    = cfg_ready && cfg_valid;
    if (int'(room) > WORD_W) n_use = BL_W'(WORD_W);
    else                     n_use = BL_W'(room);
  end

  // Next buffer contents: load a fresh word or step past the bit just shifted.
  always_comb begin
    sreg_nxt = sreg;
    bl_nxt   = bits_left;
    if (accept) begin
      sreg_nxt = cfg_data;
      bl_nxt   = n_use;
    end else if (shift_en) begin
      sreg_nxt = sreg >> 1;
      bl_nxt   = bits_left - BL_W'(1);
    end
  end

  // Registered buffer and chain outputs; head keeps its value during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      bits_left <= '0;
      head      <= 1'b0;
      shift_en  <= 1'b0;
    end else if (!run) begin
      sreg      <= '0;
      bits_left <= '0;
      shift_en  <= 1'b0;
    end else begin
      sreg      <= sreg_nxt;
      bits_left <= bl_nxt;
      shift_en  <= (bl_nxt != '0);
      if (bl_nxt != '0) head <= sreg_nxt[0];
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Programming-side driver for a tile configuration chain. Runs load or
// load+verify passes of exactly CHAIN_LEN bits, fed from a word stream.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter  int CHAIN_LEN = 17,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count,
  output state_t            state_dbg
);

  state_t           state;
  logic             verify_q;
  logic             run;
  logic [CNT_W-1:0] avail;

  // Abort drops run in its own cycle so no word is taken while stopping.
  assign run       = (state == ST_SHIFT) && !abort;
  assign avail     = CNT_W'(CHAIN_LEN) - bit_count;
  assign state_dbg = state;

  ccff_loader_serializer #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_serializer (
    .clk       (prog_clk),
    .rst_n     (pReset_n),
    .run       (run),
    .avail     (avail),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .head      (ccff_head),
    .shift_en  (ccff_shift_en)
  );

  // Pass control: state, bit counter, verify comparator and status flags.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state     <= ST_IDLE;
      verify_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      bit_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SHIFT;
            verify_q  <= verify;
            busy      <= 1'b1;
            error     <= 1'b0;
            bit_count <= '0;
          end
        end
        ST_SHIFT: begin
          if (ccff_shift_en && (bit_count != CNT_W'(CHAIN_LEN)))
            bit_count <= bit_count + CNT_W'(1);
          // A chain re-fed its own contents returns them in order, so the
          // tail must equal the bit currently on head.
          if (verify_q && ccff_shift_en && (ccff_tail != ccff_head))
            error <= 1'b1;
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (ccff_shift_en && (bit_count == CNT_W'(CHAIN_LEN - 1))) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
